// File: rtl/memory_param_2r1w.sv
// Parametrised 1W/2R memory with a clear engine; registered reads (1 cycle), write-first bypass.
// Writes during a clear sweep or alongside CLR are dropped and flagged by WDROP one cycle later.
module memory_param_2r1w #(
    parameter int                WIDTH = 2,
    parameter int                AW    = 3,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             WR,
    input  logic [AW-1:0]    AD,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RA0,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             BUSY,
    output logic             WDROP
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_acc;

    assign BUSY   = (state == S_CLEAR);
    assign wr_acc = WR && (state == S_READY) && !CLR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // CLR takes priority in either state and restarts the sweep from word 0.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (CLR) begin
            state_nxt = S_CLEAR;
            ptr_nxt   = '0;
        end else if (state == S_CLEAR) begin
            ptr_nxt = ptr + AW'(1);
            if (ptr == AW'(DEPTH - 1)) begin
                state_nxt = S_READY;
            end
        end
    end

    // Array has no reset; the sweep is what initialises it.
    always_ff @(posedge CLK) begin
        if (BUSY) begin
            mem[ptr] <= INIT;
        end else if (wr_acc) begin
            mem[AD] <= D;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q0    <= INIT;
            Q1    <= INIT;
            WDROP <= 1'b0;
        end else begin
            WDROP <= WR && (BUSY || CLR);
            if (BUSY) begin
                Q0 <= INIT;
                Q1 <= INIT;
            end else begin
                Q0 <= (wr_acc && (RA0 == AD)) ? D : mem[RA0];
                Q1 <= (wr_acc && (RA1 == AD)) ? D : mem[RA1];
            end
        end
    end

endmodule

// File: tb/tb_memory_param_2r1w.sv
// Directed bench for memory_param_2r1w at default parameters (WIDTH=2, AW=3, INIT=0).
module tb_memory_param_2r1w;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLR = 1'b0;
    logic       WR  = 1'b0;
    logic [2:0] AD  = '0;
    logic [1:0] D   = '0;
    logic [2:0] RA0 = '0;
    logic [2:0] RA1 = '0;
    logic [1:0] Q0, Q1;
    logic       BUSY, WDROP;

    int n_checks = 0;
    int n_fail   = 0;

    memory_param_2r1w dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .WR(WR), .AD(AD), .D(D),
        .RA0(RA0), .RA1(RA1), .Q0(Q0), .Q1(Q1), .BUSY(BUSY), .WDROP(WDROP)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 8'(BUSY), 8'd1);
            step();
            chk({tag, "_q0"}, 8'(Q0), 8'd0);
            chk({tag, "_q1"}, 8'(Q1), 8'd0);
        end
        chk({tag, "_done"}, 8'(BUSY), 8'd0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            RA0 = 3'(a);
            RA1 = 3'(7 - a);
            step();
            chk({tag, "_q0"}, 8'(Q0), 8'd0);
            chk({tag, "_q1"}, 8'(Q1), 8'd0);
        end
    endtask

    initial begin
        // 1: reset state and initial sweep
        #3;
        chk("rst_busy", 8'(BUSY), 8'd1);
        chk("rst_q0", 8'(Q0), 8'd0);
        chk("rst_q1", 8'(Q1), 8'd0);
        chk("rst_wdrop", 8'(WDROP), 8'd0);
        step();
        RST = 1'b0;
        sweep_check("init_sweep");
        read_all_zero("init_read");

        // 2: plain write then read, plus top address
        WR = 1'b1; AD = 3'd5; D = 2'b11; RA0 = 3'd0; RA1 = 3'd0;
        step();
        AD = 3'd7; D = 2'b01;
        step();
        WR = 1'b0; RA0 = 3'd5; RA1 = 3'd4;
        step();
        chk("wr5_q0", 8'(Q0), 8'd3);
        chk("rd4_q1", 8'(Q1), 8'd0);
        chk("no_drop", 8'(WDROP), 8'd0);
        RA1 = 3'd7;
        step();
        chk("wr7_q1", 8'(Q1), 8'd1);

        // 3: write-first bypass on both ports
        WR = 1'b1; AD = 3'd3; D = 2'b10; RA0 = 3'd3; RA1 = 3'd3;
        step();
        chk("byp_q0", 8'(Q0), 8'd2);
        chk("byp_q1", 8'(Q1), 8'd2);
        WR = 1'b0; RA1 = 3'd5;
        step();
        chk("w3_after", 8'(Q0), 8'd2);
        chk("w5_kept", 8'(Q1), 8'd3);

        // 4: fill with 11, then a CLR pulse
        WR = 1'b1; D = 2'b11;
        for (int a = 0; a < 8; a++) begin
            AD = 3'(a);
            step();
        end
        WR = 1'b0; RA0 = 3'd6; RA1 = 3'd1;
        step();
        chk("fill6", 8'(Q0), 8'd3);
        chk("fill1", 8'(Q1), 8'd3);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_q0_pre", 8'(Q0), 8'd3);
        sweep_check("clr_sweep");
        read_all_zero("clr_read");

        // 5: dropped write during sweep, restart of sweep, WR with CLR
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        step();
        WR = 1'b1; AD = 3'd2; D = 2'b01;
        step();
        WR = 1'b0;
        chk("drop_busy", 8'(WDROP), 8'd1);
        step();
        chk("drop_pulse_end", 8'(WDROP), 8'd0);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        sweep_check("restart_sweep");
        RA0 = 3'd2;
        step();
        chk("drop_word2", 8'(Q0), 8'd0);
        WR = 1'b1; CLR = 1'b1; AD = 3'd1; D = 2'b11; RA0 = 3'd1;
        step();
        WR = 1'b0; CLR = 1'b0;
        chk("drop_clr", 8'(WDROP), 8'd1);
        chk("drop_clr_busy", 8'(BUSY), 8'd1);
        chk("drop_clr_nobyp", 8'(Q0), 8'd0);
        sweep_check("wrclr_sweep");

        // 6: asynchronous reset mid-operation
        WR = 1'b1; AD = 3'd4; D = 2'b11; RA0 = 3'd4; RA1 = 3'd4;
        step();
        WR = 1'b0;
        chk("pre_rst_q0", 8'(Q0), 8'd3);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_q0", 8'(Q0), 8'd0);
        chk("arst_q1", 8'(Q1), 8'd0);
        chk("arst_busy", 8'(BUSY), 8'd1);
        step();
        step();
        RST = 1'b0;
        sweep_check("rst_sweep");
        step();
        chk("rst_word4", 8'(Q0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
